// File: rtl/tt_vend_pkg.sv
// Shared vending definitions: dispenser state encoding, change codes in quarter units,
// and the value of one quarter in cents.
package tt_vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ITEM,
        ST_GAP,
        ST_EJECT,
        ST_WAIT_ACK,
        ST_FAULT
    } state_t;

    // Change owed, counted in quarters; the owed register reuses this encoding.
    localparam logic [1:0] CH_0  = 2'b00;
    localparam logic [1:0] CH_25 = 2'b01;
    localparam logic [1:0] CH_50 = 2'b10;
    localparam logic [1:0] CH_75 = 2'b11;

    localparam int QUARTER_CENTS = 25;

endpackage

// File: rtl/tt_pulse_timer.sv
// Down-counter for state durations: load N-1 on entry, done is high on the state's last cycle.
module tt_pulse_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/tt_change_dispenser.sv
// Item release and quarter payout sequencer with coin-sensor handshake, jam detection
// and a saturating quarter inventory.
module tt_change_dispenser
    import tt_vend_pkg::*;
#(
    parameter int INV_W       = 6,
    parameter int INV_INIT    = 20,
    parameter int ITEM_CYC    = 4,
    parameter int PULSE_CYC   = 3,
    parameter int GAP_CYC     = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             dispense,
    input  logic [1:0]       change,
    input  logic             coin_sensed,
    input  logic             refill,
    input  logic [INV_W-1:0] refill_count,
    output logic             item_release,
    output logic             eject_quarter,
    output logic             busy,
    output logic             fault,
    output logic             short_change,
    output logic             req_dropped,
    output logic [INV_W-1:0] coins_left
);

    localparam int TMR_W = 8;
    localparam int SUM_W = INV_W + 2;
    localparam logic [SUM_W-1:0] INV_MAX = SUM_W'((1 << INV_W) - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [1:0]       owed_reg;
    logic             ack_early_reg;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;
    logic             take_coin;
    logic             short_now;
    logic [1:0]       owed_accept;
    logic [SUM_W-1:0] inv_sum;
    logic [INV_W-1:0] coins_next;

    tt_pulse_timer #(.W(TMR_W)) u_timer (
        .clock    (clock),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Owed is clamped to what the chute actually holds at accept time.
    assign short_now   = (INV_W'(change) > coins_left);
    assign owed_accept = short_now ? coins_left[1:0] : change;

    always_comb begin
        inv_sum = SUM_W'(coins_left) + (refill ? SUM_W'(refill_count) : '0);
        if (take_coin && inv_sum != '0) begin
            inv_sum = inv_sum - SUM_W'(1);
        end
        coins_next = (inv_sum > INV_MAX) ? INV_MAX[INV_W-1:0] : inv_sum[INV_W-1:0];
    end

    always_comb begin
        state_next = state_reg;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        take_coin  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (dispense) begin
                    state_next = ST_ITEM;
                    tmr_load   = 1'b1;
                    tmr_val    = TMR_W'(ITEM_CYC - 1);
                end
            end
            ST_ITEM: begin
                if (tmr_done) begin
                    state_next = ST_GAP;
                    tmr_load   = 1'b1;
                    tmr_val    = TMR_W'(GAP_CYC - 1);
                end
            end
            ST_GAP: begin
                if (tmr_done) begin
                    if (owed_reg == CH_0) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_EJECT;
                        tmr_load   = 1'b1;
                        tmr_val    = TMR_W'(PULSE_CYC - 1);
                    end
                end
            end
            ST_EJECT: begin
                // A coin that drops while the ejector is still driven counts once.
                take_coin = coin_sensed && !ack_early_reg;
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (ack_early_reg || take_coin) begin
                        state_next = ST_GAP;
                        tmr_val    = TMR_W'(GAP_CYC - 1);
                    end else begin
                        state_next = ST_WAIT_ACK;
                        tmr_val    = TMR_W'(ACK_TIMEOUT - 1);
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (coin_sensed) begin
                    take_coin  = 1'b1;
                    state_next = ST_GAP;
                    tmr_load   = 1'b1;
                    tmr_val    = TMR_W'(GAP_CYC - 1);
                end else if (tmr_done) begin
                    state_next = ST_FAULT;
                end
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            owed_reg      <= '0;
            ack_early_reg <= 1'b0;
            coins_left    <= INV_W'(INV_INIT);
            item_release  <= 1'b0;
            eject_quarter <= 1'b0;
            busy          <= 1'b0;
            fault         <= 1'b0;
            short_change  <= 1'b0;
            req_dropped   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            item_release  <= (state_next == ST_ITEM);
            eject_quarter <= (state_next == ST_EJECT);
            busy          <= (state_next inside {ST_ITEM, ST_GAP, ST_EJECT, ST_WAIT_ACK});
            fault         <= (state_next == ST_FAULT);
            short_change  <= (state_reg == ST_IDLE) && dispense && short_now;
            req_dropped   <= (state_reg != ST_IDLE) && dispense;
            if (state_reg == ST_IDLE && dispense) begin
                owed_reg <= owed_accept;
            end else if (take_coin) begin
                owed_reg <= owed_reg - 2'd1;
            end
            ack_early_reg <= (state_next == ST_EJECT) && (ack_early_reg || take_coin);
            coins_left    <= coins_next;
        end
    end

endmodule
